// File: rtl/decode_queue.sv
// decode_queue: pre-decoding instruction FIFO between fetch and the D/E register.
// Define DECQ_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [18:0]      out_dec,
    output logic             out_unknown,
    output logic [CNT_W-1:0] count
`ifdef DECQ_ILLEGAL_CNT_EN
    ,
    output logic [15:0]      illegal_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    // bgezalr shares REGIMM opcode 000001; its function code is fixed here.
    localparam logic [5:0] FUNC_BGEZALR = 6'b000000;

    logic [5:0] op, fn;
    logic nop, r_type;
    logic [18:0] dec;
    logic unk;

    assign op = in_instr[31:26];
    assign fn = in_instr[5:0];
    assign nop = in_instr == 32'h0;
    assign r_type = op == 6'b000000 && !nop;

    always_comb begin
        dec = '0;
        dec[0]  = nop;
        dec[1]  = r_type && fn == 6'b100001;
        dec[2]  = r_type && fn == 6'b100011;
        dec[3]  = op == 6'b001101;
        dec[4]  = op == 6'b001111;
        dec[5]  = op == 6'b100011;
        dec[6]  = op == 6'b101011;
        dec[7]  = op == 6'b000100;
        dec[8]  = op == 6'b000010;
        dec[9]  = op == 6'b000011;
        dec[10] = r_type && fn == 6'b001000;
        dec[11] = r_type && fn == 6'b001001;
        dec[12] = op == 6'b000111;
        dec[13] = op == 6'b100000;
        dec[14] = op == 6'b101000;
        dec[15] = op == 6'b101001;
        dec[16] = op == 6'b100001;
        dec[17] = op == 6'b000001 && fn == FUNC_BGEZALR;
        dec[18] = op == 6'b011100 && fn == 6'b100000;
    end

    assign unk = dec == '0;

    logic [31:0]      instr_q [DEPTH];
    logic [PC_W-1:0]  pc_q    [DEPTH];
    logic [18:0]      dec_q   [DEPTH];
    logic             unk_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic full, empty, push, pop;

    assign full  = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d  = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            instr_q[wr_ptr_q] <= in_instr;
            pc_q[wr_ptr_q]    <= in_pc;
            dec_q[wr_ptr_q]   <= dec;
            unk_q[wr_ptr_q]   <= unk;
        end
    end

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign out_instr   = out_valid ? instr_q[rd_ptr_q] : '0;
    assign out_pc      = out_valid ? pc_q[rd_ptr_q] : '0;
    assign out_dec     = out_valid ? dec_q[rd_ptr_q] : '0;
    assign out_unknown = out_valid && unk_q[rd_ptr_q];
    assign count       = count_q;

`ifdef DECQ_ILLEGAL_CNT_EN
    logic [15:0] ill_q, ill_d;

    assign ill_d = (push && !flush && unk && ill_q != 16'hFFFF) ? ill_q + 16'd1 : ill_q;

    always_ff @(posedge clk) begin
        if (reset) ill_q <= '0;
        else ill_q <= ill_d;
    end

    assign illegal_cnt = ill_q;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed plus random checks of decode_queue against a queue-based model.
module tb_decode_queue;
    localparam int DEPTH = 4;
    // Decode table: opcode and function (-1 = any) for bits 1..18; bit 0 is the all-zero word.
    localparam int OP [19] = '{0, 0, 0, 13, 15, 35, 43, 4, 2, 3, 0, 0, 7, 32, 40, 41, 33, 1, 28};
    localparam int FN [19] = '{-1, 33, 35, -1, -1, -1, -1, -1, -1, -1, 8, 9, -1, -1, -1, -1, -1, 0, 32};

    logic clk = 0;
    logic reset, flush, in_valid, in_ready, out_valid, out_ready, out_unknown;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [18:0] out_dec;
    logic [2:0] count;
`ifdef DECQ_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_dec(out_dec), .out_unknown(out_unknown), .count(count)
`ifdef DECQ_ILLEGAL_CNT_EN
        , .illegal_cnt(illegal_cnt)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int ill_m = 0;
    logic [63:0] mq [$];

    function automatic logic [18:0] ref_dec(input logic [31:0] w);
        if (w == 32'h0) return 19'h1;
        for (int k = 1; k < 19; k++)
            if (int'(w[31:26]) == OP[k] && (FN[k] < 0 || int'(w[5:0]) == FN[k]))
                return 19'h1 << k;
        return 19'h0;
    endfunction

    function automatic logic [31:0] gen_instr();
        int k;
        logic [31:0] w;
        k = $urandom_range(0, 21);
        w = $urandom;
        if (k == 0) return 32'h0;
        if (k > 18) return w;
        w[31:26] = 6'(OP[k]);
        if (FN[k] >= 0) w[5:0] = 6'(FN[k]);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all();
        logic [31:0] hi, hp;
        logic [18:0] hd;
        logic v;
        v  = mq.size() != 0;
        hi = v ? mq[0][63:32] : 32'h0;
        hp = v ? mq[0][31:0] : 32'h0;
        hd = v ? ref_dec(hi) : 19'h0;
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), mq.size());
        chk("out_instr", out_instr, hi);
        chk("out_pc", out_pc, hp);
        chk("out_dec", 32'(out_dec), 32'(hd));
        chk("out_unknown", 32'(out_unknown), 32'(v && hd == 19'h0));
`ifdef DECQ_ILLEGAL_CNT_EN
        chk("illegal_cnt", 32'(illegal_cnt), ill_m);
`endif
    endtask

    task automatic step(input logic rs, input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [31:0] p, input logic ordy);
        logic can_push, can_pop;
        reset = rs; flush = fl; in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy;
        @(posedge clk);
        can_push = mq.size() < DEPTH;
        can_pop  = mq.size() > 0 && ordy;
        if (rs) begin
            mq.delete();
            ill_m = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (can_pop) void'(mq.pop_front());
            if (iv && can_push) begin
                mq.push_back({ins, p});
                if (ref_dec(ins) == 19'h0 && ill_m < 65535) ill_m++;
            end
        end
        #1 check_all();
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(count), 0);
        // Fill: addu, nop, illegal, lui; fifth push dropped.
        step(0, 0, 1, 32'h02328021, 32'h3000, 0);
        chk("addu_dec", 32'(out_dec), 32'h2);
        chk("addu_pc", out_pc, 32'h3000);
        chk("addu_count", 32'(count), 1);
        step(0, 0, 1, 32'h00000000, 32'h3004, 0);
        step(0, 0, 1, 32'hFC000000, 32'h3008, 0);
`ifdef DECQ_ILLEGAL_CNT_EN
        chk("ill_one", 32'(illegal_cnt), 1);
`endif
        step(0, 0, 1, 32'h3C011234, 32'h300C, 0);
        chk("full_ready", 32'(in_ready), 0);
        step(0, 0, 1, 32'h34210001, 32'h3010, 0);
        chk("full_count", 32'(count), 4);
        step(0, 0, 0, 0, 0, 1);
        chk("nop_dec", 32'(out_dec), 32'h1);
        chk("nop_unknown", 32'(out_unknown), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("ill_dec", 32'(out_dec), 0);
        chk("ill_unknown", 32'(out_unknown), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("lui_dec", 32'(out_dec), 32'h10);
        step(0, 0, 0, 0, 0, 1);
        chk("drain_valid", 32'(out_valid), 0);
        // Streaming at count 2 across pointer wrap.
        step(0, 0, 1, 32'h3C011234, 32'h4000, 0);
        step(0, 0, 1, 32'h34210001, 32'h4004, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, (i % 2) ? 32'h34210001 : 32'h3C011234, 32'h4008 + 4 * i, 1);
            chk("stream_count", 32'(count), 2);
        end
        // Flush at count 3 with simultaneous push and pop.
        step(0, 0, 1, 32'h02328021, 32'h5000, 0);
        chk("pre_flush_count", 32'(count), 3);
        step(0, 1, 1, 32'hDEADBEEF, 32'h5004, 1);
        chk("flush_count", 32'(count), 0);
        chk("flush_ready", 32'(in_ready), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("flush_dropped", 32'(out_valid), 0);
        // Reset with flush while holding two entries.
        step(0, 0, 1, 32'hFC000000, 32'h6000, 0);
        step(0, 0, 1, 32'h8C220004, 32'h6004, 0);
        step(1, 1, 1, 32'h02328021, 32'h6008, 1);
        chk("rst_mid_valid", 32'(out_valid), 0);
`ifdef DECQ_ILLEGAL_CNT_EN
        chk("rst_ill", 32'(illegal_cnt), 0);
`endif
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                 gen_instr(), $urandom, $urandom_range(0, 2) != 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction decode buffer between the fetch stage and the D/E pipeline register of the P5 MIPS core.
- Accepts fetched instruction/PC pairs through a valid/ready handshake.
- Decodes each entry into a one-hot instruction vector at enqueue time and stores the result in a DEPTH-entry circular FIFO.
- Presents registered, pre-decoded entries to the downstream stage, with synchronous flush for branch/jump redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PC_W, 32, width of the stored PC.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear (redirect).
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue can accept; equals !full.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry is valid; equals !empty.
- out_ready  input  1  downstream consumes the head.
- out_instr  output  32  head instruction word.
- out_pc  output  PC_W  head PC.
- out_dec  output  19  one-hot decode of the head entry (bit map below).
- out_unknown  output  1  head entry matched no decode bit.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. Clock port is named clk, reset port is named reset.
- Reset clears read pointer, write pointer and count to 0. All outputs read 0: out_valid=0, out_dec=0, out_unknown=0, out_instr=0, out_pc=0, count=0. in_ready=1 after reset.
- out_dec bit map:
  - bit0 nop (word 0x00000000)
  - bit1 addu (op 000000, func 100001)
  - bit2 subu (op 000000, func 100011)
  - bit3 ori (op 001101)
  - bit4 lui (op 001111)
  - bit5 lw (op 100011)
  - bit6 sw (op 101011)
  - bit7 beq (op 000100)
  - bit8 j (op 000010)
  - bit9 jal (op 000011)
  - bit10 jr (op 000000, func 001000)
  - bit11 jalr (op 000000, func 001001)
  - bit12 bgtz (op 000111)
  - bit13 lb (op 100000)
  - bit14 sb (op 101000)
  - bit15 sh (op 101001)
  - bit16 lh (op 100001)
  - bit17 bgezalr (op 000001, func per the shared opcode header)
  - bit18 clz (op 011100, func 100000)
- Decode rules:
  - nop takes precedence over the R-type bits, so word 0 sets only bit0.
  - At most one bit is set. out_unknown = (decode == 0).
- Push: in_valid && in_ready at the edge. Writes the instr, PC, decode vector and unknown flag at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: out_valid && out_ready at the edge. Increments the read pointer modulo DEPTH.
- Latency: an entry pushed at edge N is visible at the outputs from edge N+1, with no combinational input-to-output path.
- Output data is read from the registered array at the read pointer. When out_valid=0, out_instr, out_pc, out_dec and out_unknown are forced to 0.
- Full (count==DEPTH):
  - in_ready=0 and pushes are ignored.
  - A simultaneous out_ready pops only; in_ready does not depend on out_ready.
- Empty (count==0): out_valid=0 and out_ready is ignored.
- Push and pop in the same cycle when neither full nor empty: both pointers advance and count is unchanged.
- Wrap-around: pointers wrap from DEPTH-1 to 0; FIFO ordering is preserved across the wrap.
- Flush:
  - Has priority over push and pop in the same cycle. Pointers and count are cleared and the input entry is dropped.
  - out_valid=0 on the next cycle.
- Reset has priority over flush. Reset asserted mid-stream discards all entries.
- There is no state machine beyond the pointer/count logic. count is updated as count + push - pop and never exceeds DEPTH.

Optional Feature:
- Macro: DECQ_ILLEGAL_CNT_EN.
- When defined:
  - Adds output illegal_cnt, 16 bits.
  - Increments by one on every accepted push whose decode is unknown.
  - Saturates at 0xFFFF.
  - Cleared by reset only, not by flush.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then push 0x02328021 (addu) at PC 0x3000 -> next cycle out_valid=1, out_dec=bit1, out_pc=0x3000, count=1.
- Push 0x00000000 -> out_dec=bit0 only, out_unknown=0. Push 0xFC000000 -> out_unknown=1, out_dec=0; illegal_cnt=1 when DECQ_ILLEGAL_CNT_EN is defined.
- DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after the 4th push, 5th dropped, count=4. Then pop 4 -> words emerge in order; out_valid=0 after the last pop.
- Continuous push+pop for 10 cycles with count=2 -> count stays 2, order preserved across pointer wrap, with lui 0x3C011234 and ori 0x34210001 interleaved and decoded correctly.
- Flush asserted together with in_valid and out_ready at count=3 -> next cycle count=0, out_valid=0, in_ready=1, and the pushed word is never output.
- Reset asserted while count=2 and flush=1 -> all outputs 0 next cycle; illegal_cnt=0 when DECQ_ILLEGAL_CNT_EN is defined.
